pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter controller for the single-issue core; owns the PC register and sequences instruction fetch.
- Drives the 16-entry branch-target lookup table's address and consumes its combinational target output.
- Applies either a PC-relative (two's-complement offset) or an absolute jump.
- Runs a start/done handshake with the testbench/top level and counts executed cycles.

Parameters:
D, 12, PC and branch-target width in bits
LA, 4, lookup-table address width (16 entries)
CW, 16, cycle-counter width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  one-cycle request to begin execution from PC 0
stall  input  1  hold PC this cycle (memory/datapath not ready)
branch_taken  input  1  resolved branch/jump request this cycle
abs_jump  input  1  with branch_taken: 1 = absolute target, 0 = PC-relative offset
lut_idx  input  LA  table index supplied by decode
halt_req  input  1  decode saw the halt instruction
lut_addr  output  LA  address to branch-target table
lut_target  input  D  target/offset returned by table, same cycle
pc  output  D  current program counter (instruction address)
fetch_valid  output  1  pc is a valid fetch address this cycle
busy  output  1  sequencer in RUN
done  output  1  program finished; level, held until next start
cycles  output  CW  cycles spent in RUN since last start

Behaviour:
- Reset (async, active-high): state=IDLE, pc=0, done=0, cycles=0. Outputs fetch_valid=0 and busy=0 follow from state.
- lut_addr = lut_idx combinationally in all states. lut_target is sampled in the same cycle it is presented; no extra latency.
- States: IDLE, RUN, HALTED.
- IDLE: start=1 -> RUN next edge, pc<=0, cycles<=0, done<=0. All other inputs ignored.
- RUN, priority per rising edge, highest first:
  1. stall=1: pc holds; halt_req and branch_taken ignored this cycle.
  2. halt_req=1: -> HALTED, done<=1, pc holds (points at halt instruction).
  3. branch_taken=1, abs_jump=1: pc<=lut_target.
  4. branch_taken=1, abs_jump=0: pc<=(pc+lut_target) mod 2^D. lut_target is a two's-complement offset; 0xFFF = -1, 0x000 = +0 (pc unchanged).
  5. Otherwise: pc<=(pc+1) mod 2^D; 0xFFF wraps to 0x000.
- RUN counter: cycles increments every RUN cycle, stalled or not, including the halting cycle. It saturates at 2^CW-1 and does not wrap.
- RUN, start=1: ignored.
- HALTED: done=1 held, pc and cycles frozen. start=1 -> RUN with pc<=0, cycles<=0, done<=0 (restart).
- Combinational status: fetch_valid = (state==RUN) && !stall. busy = (state==RUN).
- Reset mid-RUN or mid-HALTED returns to IDLE at once. No partial update survives.
- Undefined encodings of the state register recover to IDLE.
- Width rule: all PC arithmetic is D bits, carry discarded. No sign extension is needed since offset width equals D.

Test Plan:
- Reset, start pulse, 5 cycles no branch -> pc sequence 0,1,2,3,4,5; fetch_valid=1; cycles=5; done=0.
- Relative branches:
  - at pc=4, branch_taken=1, abs_jump=0, lut_target=0xFFF -> pc=3.
  - at pc=4, lut_target=0x014 -> pc=0x018.
  - at pc=0x010, lut_target=0xFFB -> pc=0x00B.
- Absolute jump and wrap:
  - lut_idx=7, lut_target=0xFFF, abs_jump=1 -> lut_addr=7, pc=0xFFF.
  - next cycle no branch -> pc=0x000.
- Simultaneous events at pc=9:
  - stall+halt_req+branch_taken -> pc stays 9, state RUN.
  - next cycle halt_req+branch_taken -> done=1, pc=9, busy=0.
  - further inputs leave pc and cycles frozen.
- Restart and reset:
  - start in HALTED -> pc=0, cycles=0, done=0, busy=1.
  - assert reset asynchronously mid-RUN at pc=0x2A -> pc=0, state IDLE, no clock edge required.
- Counter saturation (CW overridden to 4): 20 RUN cycles -> cycles=15 and stays 15.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter controller for the single-issue core.
// Owns the PC register and sequences fetch through IDLE -> RUN -> HALTED.
// It drives the branch-target table address and uses the table's
// same-cycle target, either as an absolute jump or as a two's-complement
// PC-relative offset. It also counts the cycles spent in RUN.
//
// Ports:
//   clk, reset              clock; reset is asynchronous and active-high
//   start                   begin (or restart) execution at PC 0
//   stall                   hold PC this cycle
//   branch_taken, abs_jump  branch request; abs_jump selects absolute or relative
//   lut_idx -> lut_addr     table index passed straight through to the table
//   lut_target              table output for the current lut_addr
//   halt_req                decode saw the halt instruction
//   pc, fetch_valid         current fetch address and its qualifier
//   busy, done              RUN status; done stays high until the next start
//   cycles                  saturating count of RUN cycles since the last start
module pc_sequencer #(
  parameter int D  = 12,
  parameter int LA = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic          abs_jump,
  input  logic [LA-1:0] lut_idx,
  input  logic          halt_req,
  output logic [LA-1:0] lut_addr,
  input  logic [D-1:0]  lut_target,
  output logic [D-1:0]  pc,
  output logic          fetch_valid,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cycles
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_t;

  localparam logic [D-1:0]  PC_ONE  = {{(D-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CYC_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CYC_MAX = {CW{1'b1}};

  state_t state, state_nxt;

  assign lut_addr = lut_idx;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state. A stall beats halt_req, so a stalled halt stays in RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (!stall && halt_req) state_nxt = HALTED;
      HALTED:  if (start) state_nxt = RUN;
      default: state_nxt = IDLE;  // unused encoding recovers
    endcase
  end

  // Output decode
  always_comb begin
    busy        = (state == RUN);
    fetch_valid = (state == RUN) && !stall;
  end

  // PC, cycle counter and done flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= '0;
      cycles <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            pc     <= '0;
            cycles <= '0;
            done   <= 1'b0;
          end
        end
        RUN: begin
          // Counts stalled cycles and the halting cycle as well.
          if (cycles != CYC_MAX) cycles <= cycles + CYC_ONE;
          if (stall) begin
            pc <= pc;
          end else if (halt_req) begin
            done <= 1'b1;  // pc stays on the halt instruction
          end else if (branch_taken) begin
            // Offset is D bits wide, so a plain add with the carry dropped
            // gives the two's-complement result.
            pc <= abs_jump ? lut_target : pc + lut_target;
          end else begin
            pc <= pc + PC_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stall, branch_taken, abs_jump, halt_req;
  logic [3:0]  lut_idx;
  logic [11:0] lut_target;

  logic [3:0]  lut_addr;
  logic [11:0] pc;
  logic        fetch_valid, busy, done;
  logic [15:0] cycles;

  logic [3:0]  s_lut_addr;
  logic [11:0] s_pc;
  logic        s_fetch_valid, s_busy, s_done;
  logic [3:0]  s_cycles;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.D(12), .LA(4), .CW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_taken(branch_taken), .abs_jump(abs_jump), .lut_idx(lut_idx),
    .halt_req(halt_req), .lut_addr(lut_addr), .lut_target(lut_target),
    .pc(pc), .fetch_valid(fetch_valid), .busy(busy), .done(done),
    .cycles(cycles)
  );

  pc_sequencer #(.D(12), .LA(4), .CW(4)) u_sat (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_taken(branch_taken), .abs_jump(abs_jump), .lut_idx(lut_idx),
    .halt_req(halt_req), .lut_addr(s_lut_addr), .lut_target(lut_target),
    .pc(s_pc), .fetch_valid(s_fetch_valid), .busy(s_busy), .done(s_done),
    .cycles(s_cycles)
  );

  typedef struct {
    logic        start, stall, br, abs_j, halt;
    logic [3:0]  idx;
    logic [11:0] tgt;
    logic [11:0] epc;
    logic        efv, ebusy, edone;
    logic [15:0] ecyc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic st, logic sl, logic br, logic ab, logic ht,
                              logic [3:0] idx, logic [11:0] tgt, logic [11:0] epc,
                              logic efv, logic eb, logic ed, logic [15:0] ec);
    vec_t v;
    v.start = st; v.stall = sl; v.br = br; v.abs_j = ab; v.halt = ht;
    v.idx = idx; v.tgt = tgt; v.epc = epc; v.efv = efv; v.ebusy = eb;
    v.edone = ed; v.ecyc = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic sl, input logic br, input logic ab,
                       input logic ht, input logic [3:0] idx, input logic [11:0] tgt);
    start = st; stall = sl; branch_taken = br; abs_jump = ab; halt_req = ht;
    lut_idx = idx; lut_target = tgt;
  endtask

  task automatic chk_all(input string tag, input logic [11:0] epc, input logic efv,
                         input logic eb, input logic ed, input logic [15:0] ec);
    chk({tag, " pc"}, 32'(pc), 32'(epc));
    chk({tag, " fetch_valid"}, 32'(fetch_valid), 32'(efv));
    chk({tag, " busy"}, 32'(busy), 32'(eb));
    chk({tag, " done"}, 32'(done), 32'(ed));
    chk({tag, " cycles"}, 32'(cycles), 32'(ec));
  endtask

  initial begin
    //          st sl br ab ht idx   tgt      pc    fv bsy dn cyc
    vq.push_back(mk(0, 0, 1, 1, 1, 4'd3, 12'h055, 12'h000, 0, 0, 0, 16'd0));  // IDLE ignores
    vq.push_back(mk(1, 0, 0, 0, 0, 4'd0, 12'h000, 12'h000, 1, 1, 0, 16'd0));  // start
    vq.push_back(mk(0, 0, 0, 0, 0, 4'd0, 12'h000, 12'h001, 1, 1, 0, 16'd1));
    vq.push_back(mk(0, 0, 0, 0, 0, 4'd0, 12'h000, 12'h002, 1, 1, 0, 16'd2));
    vq.push_back(mk(0, 0, 0, 0, 0, 4'd0, 12'h000, 12'h003, 1, 1, 0, 16'd3));
    vq.push_back(mk(0, 0, 0, 0, 0, 4'd0, 12'h000, 12'h004, 1, 1, 0, 16'd4));
    vq.push_back(mk(0, 0, 0, 0, 0, 4'd0, 12'h000, 12'h005, 1, 1, 0, 16'd5));
    vq.push_back(mk(0, 0, 1, 0, 0, 4'd1, 12'hFFF, 12'h004, 1, 1, 0, 16'd6));  // -1
    vq.push_back(mk(0, 0, 1, 0, 0, 4'd1, 12'hFFF, 12'h003, 1, 1, 0, 16'd7));  // at 4 -> 3
    vq.push_back(mk(0, 0, 0, 0, 0, 4'd0, 12'h000, 12'h004, 1, 1, 0, 16'd8));
    vq.push_back(mk(0, 0, 1, 0, 0, 4'd2, 12'h014, 12'h018, 1, 1, 0, 16'd9));  // at 4 +0x14
    vq.push_back(mk(0, 0, 1, 0, 0, 4'd2, 12'hFF8, 12'h010, 1, 1, 0, 16'd10)); // -8
    vq.push_back(mk(0, 0, 1, 0, 0, 4'd5, 12'hFFB, 12'h00B, 1, 1, 0, 16'd11)); // at 0x10 -5
    vq.push_back(mk(0, 0, 1, 0, 0, 4'd5, 12'h000, 12'h00B, 1, 1, 0, 16'd12)); // +0
    vq.push_back(mk(0, 0, 1, 1, 0, 4'd7, 12'hFFF, 12'hFFF, 1, 1, 0, 16'd13)); // abs
    vq.push_back(mk(0, 0, 0, 0, 0, 4'd0, 12'h000, 12'h000, 1, 1, 0, 16'd14)); // wrap
    vq.push_back(mk(0, 0, 1, 1, 0, 4'd9, 12'h009, 12'h009, 1, 1, 0, 16'd15));
    vq.push_back(mk(0, 1, 1, 0, 1, 4'd4, 12'h100, 12'h009, 0, 1, 0, 16'd16)); // stall wins
    vq.push_back(mk(0, 0, 1, 0, 1, 4'd4, 12'h100, 12'h009, 0, 0, 1, 16'd17)); // halt wins
    vq.push_back(mk(0, 0, 1, 1, 0, 4'd6, 12'h005, 12'h009, 0, 0, 1, 16'd17)); // frozen
    vq.push_back(mk(0, 1, 0, 0, 1, 4'd6, 12'h005, 12'h009, 0, 0, 1, 16'd17)); // frozen
    vq.push_back(mk(1, 0, 0, 0, 0, 4'd0, 12'h000, 12'h000, 1, 1, 0, 16'd0));  // restart
    vq.push_back(mk(1, 0, 0, 0, 0, 4'd0, 12'h000, 12'h001, 1, 1, 0, 16'd1));  // start in RUN ignored
    vq.push_back(mk(0, 1, 0, 0, 0, 4'd0, 12'h000, 12'h001, 0, 1, 0, 16'd2));  // stall counts
    vq.push_back(mk(0, 0, 1, 1, 0, 4'hA, 12'h02A, 12'h02A, 1, 1, 0, 16'd3));

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 4'd0, 12'h000);
    #12;
    chk_all("reset", 12'h000, 1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].start, vq[i].stall, vq[i].br, vq[i].abs_j, vq[i].halt, vq[i].idx, vq[i].tgt);
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), vq[i].epc, vq[i].efv, vq[i].ebusy, vq[i].edone, vq[i].ecyc);
      chk($sformatf("v%0d lut_addr", i), 32'(lut_addr), 32'(vq[i].idx));
    end

    // Asynchronous reset in the middle of a cycle while RUN at pc=0x2A.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 4'd0, 12'h000);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 12'h000, 1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    // Saturation on the 4-bit counter instance.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("sat start cycles", 32'(s_cycles), 32'd0);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 14) chk("sat cycles@14", 32'(s_cycles), 32'd14);
      if (n == 15) chk("sat cycles@15", 32'(s_cycles), 32'd15);
    end
    chk("sat cycles@20", 32'(s_cycles), 32'd15);
    chk("wide cycles@20", 32'(cycles), 32'd20);
    chk("sat busy", 32'(s_busy), 32'd1);
    chk("sat pc", 32'(s_pc), 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
